// File: rtl/ser_out_feeder_pkg.sv
// ser_out_feeder shared types: FSM encoding and widths.
// Also used by the serial input side.
package ser_out_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    DRAIN   = 3'd4
  } state_e;

  localparam int WORD_BITS_DEF = 64;
  localparam int WCNT_W        = 16;

endpackage

// File: rtl/ser_out_feeder_if.sv
// Queue-side and serializer-side signals of ser_out_feeder.
// words_sent exists only when TX_WORD_CNT_EN is defined.
interface ser_out_feeder_if
  import ser_out_feeder_pkg::*;
#(
  parameter int WORD_BITS = WORD_BITS_DEF
);

  logic                 tx_enable;
  logic                 fifo_empty;
  logic                 fifo_rd_en;
  logic [WORD_BITS-1:0] fifo_rd_data;
  logic [WORD_BITS-1:0] data_out;
  logic                 valid_data_out;
  logic                 busy;
`ifdef TX_WORD_CNT_EN
  logic [WCNT_W-1:0]    words_sent;
`endif

  modport slave (
    input  tx_enable,
    input  fifo_empty,
    input  fifo_rd_data,
    output fifo_rd_en,
    output data_out,
    output valid_data_out,
`ifdef TX_WORD_CNT_EN
    output words_sent,
`endif
    output busy
  );

  modport master (
    output tx_enable,
    output fifo_empty,
    output fifo_rd_data,
    input  fifo_rd_en,
    input  data_out,
    input  valid_data_out,
`ifdef TX_WORD_CNT_EN
    input  words_sent,
`endif
    input  busy
  );

endinterface

// File: rtl/ser_spacing_cntr.sv
// Loadable down-counter with zero flag; saturates at zero.
// Shared by the serial output and input sides.
module ser_spacing_cntr #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ser_out_feeder.sv
// Pops words from the output queue and paces load pulses to the serializer.
// Optional macro TX_WORD_CNT_EN adds the words_sent counter.
module ser_out_feeder
  import ser_out_feeder_pkg::*;
#(
  parameter int WORD_BITS  = WORD_BITS_DEF,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_W      = 7
) (
  input  logic             clk_div_4,
  input  logic             reset_n,
  ser_out_feeder_if.slave  io
);

  localparam logic [CNT_W-1:0] SPACE_LD =
    CNT_W'(WORD_BITS - 1 + GAP_CYCLES);

  state_e               state_q;
  state_e               state_d;
  logic                 fifo_rd_en_q;
  logic                 fifo_rd_en_d;
  logic                 valid_q;
  logic                 valid_d;
  logic [WORD_BITS-1:0] data_out_q;
  logic [WORD_BITS-1:0] data_out_d;

  logic                 cnt_load;
  logic                 cnt_dec;
  logic                 cnt_zero;
  logic [CNT_W-1:0]     cnt_val;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (io.tx_enable && !io.fifo_empty) begin
          state_d = READ;
        end
      end
      READ:    state_d = CAPTURE;
      CAPTURE: state_d = SEND;
      SEND:    state_d = DRAIN;
      DRAIN: begin
        if (cnt_zero) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter reads the load value during SEND, so DRAIN ends on zero.
  always_comb begin
    cnt_load = (state_d == SEND);
    cnt_dec  = (state_q == SEND) || (state_q == DRAIN);
  end

  always_comb begin
    fifo_rd_en_d = (state_d == READ);
    valid_d      = (state_d == SEND);
    data_out_d   = data_out_q;
    if (state_q == CAPTURE) begin
      data_out_d = io.fifo_rd_data;
    end
  end

  always_ff @(posedge clk_div_4) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      fifo_rd_en_q <= 1'b0;
      valid_q      <= 1'b0;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      fifo_rd_en_q <= fifo_rd_en_d;
      valid_q      <= valid_d;
      data_out_q   <= data_out_d;
    end
  end

  ser_spacing_cntr #(
    .CNT_W (CNT_W)
  ) u_space (
    .clk      (clk_div_4),
    .rst_n    (reset_n),
    .load     (cnt_load),
    .load_val (SPACE_LD),
    .dec      (cnt_dec),
    .cnt      (cnt_val),
    .zero     (cnt_zero)
  );

`ifdef TX_WORD_CNT_EN
  logic [WCNT_W-1:0] words_sent_q;
  logic [WCNT_W-1:0] words_sent_d;

  always_comb begin
    words_sent_d = words_sent_q;
    if (state_q == SEND) begin
      words_sent_d = words_sent_q + 1'b1;
    end
  end

  always_ff @(posedge clk_div_4) begin
    if (!reset_n) begin
      words_sent_q <= '0;
    end else begin
      words_sent_q <= words_sent_d;
    end
  end

  assign io.words_sent = words_sent_q;
`endif

  logic unused_cnt;
  assign unused_cnt = ^cnt_val;

  assign io.fifo_rd_en     = fifo_rd_en_q;
  assign io.valid_data_out = valid_q;
  assign io.data_out       = data_out_q;
  assign io.busy           = (state_q != IDLE);

endmodule
